// File: rtl/jpeg_hex_stream_parser_pkg.sv
// rtl/jpeg_hex_stream_parser_pkg.sv - shared types and constants for the JPEG hex stream parser
package jpeg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_SEG,
        ST_SCAN,
        ST_SFF
    } state_t;

    localparam logic [7:0] M_SOI  = 8'hD8;
    localparam logic [7:0] M_EOI  = 8'hD9;
    localparam logic [7:0] M_SOS  = 8'hDA;
    localparam logic [7:0] M_RST0 = 8'hD0;
    localparam logic [7:0] M_TEM  = 8'h01;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_SP = 8'h20;

    // RSTn markers D0..D7 share the upper five bits of RST0
    function automatic logic is_rst_marker(input logic [7:0] code);
        return code[7:3] == M_RST0[7:3];
    endfunction

    // Markers that carry no length field
    function automatic logic is_standalone(input logic [7:0] code);
        return (code == M_SOI) || (code == M_TEM) || is_rst_marker(code);
    endfunction

endpackage

// File: rtl/jpeg_hex_stream_parser_if.sv
// rtl/jpeg_hex_stream_parser_if.sv - character input, byte output and status signals
interface jpeg_hex_stream_parser_if;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_marker;
    logic       out_scan;
    logic       err;
    logic       eoi_done;

    modport master (
        output in_char, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_marker, out_scan, err, eoi_done
    );

    modport slave (
        input  in_char, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_marker, out_scan, err, eoi_done
    );
endinterface

// File: rtl/hex_ascii_decode.sv
// rtl/hex_ascii_decode.sv - classifies one ASCII character as hex nibble, whitespace or other
module hex_ascii_decode
    import jpeg_pkg::*;
(
    input  logic [7:0] char_in,
    output logic [3:0] nib,
    output logic       is_hex,
    output logic       is_ws
);

    // Letters map via low nibble + 9 ('A'/'a' low nibble is 1 -> 10)
    always_comb begin
        nib    = 4'h0;
        is_hex = 1'b0;
        is_ws  = 1'b0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            nib    = char_in[3:0];
            is_hex = 1'b1;
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            nib    = char_in[3:0] + 4'd9;
            is_hex = 1'b1;
        end else if (char_in == CH_LF || char_in == CH_CR || char_in == CH_SP) begin
            is_ws  = 1'b1;
        end
    end

endmodule

// File: rtl/jpeg_hex_stream_parser.sv
// rtl/jpeg_hex_stream_parser.sv - hex text to JPEG byte stream with marker, segment and stuffing handling
module jpeg_hex_stream_parser
    import jpeg_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    jpeg_hex_stream_parser_if.slave       bus
);

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_sos_q, is_sos_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_marker_q, out_marker_d;
    logic        out_scan_q, out_scan_d;
    logic        err_q, err_d;
    logic        eoi_done_q, eoi_done_d;

    logic [3:0]  nib;
    logic        is_hex;
    logic        is_ws;
    logic        accept;
    logic        byte_ok;
    logic [7:0]  byte_v;
    logic        emit;
    logic [7:0]  emit_data;
    logic        emit_marker;
    logic        emit_scan;

    hex_ascii_decode u_dec (
        .char_in (bus.in_char),
        .nib     (nib),
        .is_hex  (is_hex),
        .is_ws   (is_ws)
    );

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_marker = out_marker_q;
    assign bus.out_scan   = out_scan_q;
    assign bus.err        = err_q;
    assign bus.eoi_done   = eoi_done_q;

    // Nibble assembly, byte-level parse step and output register next-state
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hi_nib_d     = hi_nib_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        is_sos_d     = is_sos_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_marker_d = out_marker_q;
        out_scan_d   = out_scan_q;
        err_d        = err_q;
        eoi_done_d   = eoi_done_q;
        byte_ok      = 1'b0;
        byte_v       = {hi_nib_q, nib};
        emit         = 1'b0;
        emit_data    = byte_v;
        emit_marker  = 1'b0;
        emit_scan    = 1'b0;

        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Everything after EOI is swallowed silently
        if (accept && !eoi_done_q) begin
            if (is_hex) begin
                if (!phase_q) begin
                    hi_nib_d = nib;
                    phase_d  = 1'b1;
                end else begin
                    phase_d  = 1'b0;
                    byte_ok  = 1'b1;
                end
            end else if (!is_ws) begin
                err_d = 1'b1;
            end
        end

        if (byte_ok) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_v == 8'hFF) begin
                        state_d = ST_MARK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_MARK, ST_SFF: begin
                    if (byte_v == 8'hFF) begin
                        state_d = state_q;
                    end else if (state_q == ST_SFF && byte_v == 8'h00) begin
                        emit      = 1'b1;
                        emit_data = 8'hFF;
                        emit_scan = 1'b1;
                        state_d   = ST_SCAN;
                    end else if (state_q == ST_SFF && is_rst_marker(byte_v)) begin
                        emit        = 1'b1;
                        emit_marker = 1'b1;
                        state_d     = ST_SCAN;
                    end else if (byte_v == 8'h00) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        emit        = 1'b1;
                        emit_marker = 1'b1;
                        if (byte_v == M_EOI) begin
                            eoi_done_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else if (is_standalone(byte_v)) begin
                            state_d = ST_IDLE;
                        end else begin
                            is_sos_d = (byte_v == M_SOS);
                            state_d  = ST_LEN_HI;
                        end
                    end
                end
                ST_LEN_HI: begin
                    emit        = 1'b1;
                    len_d[15:8] = byte_v;
                    state_d     = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    emit  = 1'b1;
                    len_d = {len_q[15:8], byte_v};
                    if (len_d < 16'd2) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (len_d == 16'd2) begin
                        state_d = is_sos_q ? ST_SCAN : ST_IDLE;
                    end else begin
                        cnt_d   = len_d - 16'd2;
                        state_d = ST_SEG;
                    end
                end
                ST_SEG: begin
                    emit  = 1'b1;
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = is_sos_q ? ST_SCAN : ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (byte_v == 8'hFF) begin
                        state_d = ST_SFF;
                    end else begin
                        emit      = 1'b1;
                        emit_scan = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (emit) begin
            out_valid_d  = 1'b1;
            out_data_d   = emit_data;
            out_marker_d = emit_marker;
            out_scan_d   = emit_scan;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            hi_nib_q     <= 4'h0;
            len_q        <= 16'h0000;
            cnt_q        <= 16'h0000;
            is_sos_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            out_marker_q <= 1'b0;
            out_scan_q   <= 1'b0;
            err_q        <= 1'b0;
            eoi_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_nib_q     <= hi_nib_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            is_sos_q     <= is_sos_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_marker_q <= out_marker_d;
            out_scan_q   <= out_scan_d;
            err_q        <= err_d;
            eoi_done_q   <= eoi_done_d;
        end
    end

endmodule

// File: tb/tb_jpeg_hex_stream_parser.sv
// tb/tb_jpeg_hex_stream_parser.sv - randomized and directed bench against a stream-level JPEG parse model
module tb_jpeg_hex_stream_parser;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    jpeg_hex_stream_parser_if bus ();

    jpeg_hex_stream_parser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output list: {marker, scan, data}
    logic [9:0] exp_q[$];
    logic       exp_err;
    logic       exp_eoi;
    logic [7:0] codes[6] = '{8'hC0, 8'hC4, 8'hDB, 8'hE0, 8'hFE, 8'hDD};

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic bit rst_code(input logic [7:0] c);
        return c >= 8'hD0 && c <= 8'hD7;
    endfunction

    task automatic model(input string s);
        logic [7:0] bq[$];
        int         bad_at[$];
        int         hi, v, i, n, code, len, eoi_idx;
        bit         ph, sos;
        logic [7:0] b, c, h8, l8;
        exp_q.delete();
        exp_err = 0;
        exp_eoi = 0;
        ph = 0;
        hi = 0;
        for (int k = 0; k < s.len(); k++) begin
            c = s[k];
            v = hexval(c);
            if (v >= 0) begin
                if (!ph) begin hi = v; ph = 1; end
                else begin bq.push_back(8'(hi * 16 + v)); ph = 0; end
            end else if (!(c == 8'h0A || c == 8'h0D || c == 8'h20)) begin
                bad_at.push_back(bq.size());
            end
        end
        n = bq.size();
        eoi_idx = n;
        i = 0;
        code = -1;
        while (1) begin
            if (code < 0) begin
                if (i >= n) break;
                b = bq[i++];
                if (b != 8'hFF) begin exp_err = 1; continue; end
                while (i < n && bq[i] == 8'hFF) i++;
                if (i >= n) break;
                code = int'(bq[i++]);
            end
            c = 8'(code);
            code = -1;
            if (c == 8'h00) begin exp_err = 1; continue; end
            exp_q.push_back({2'b10, c});
            if (c == 8'hD9) begin exp_eoi = 1; eoi_idx = i - 1; break; end
            if (c == 8'hD8 || c == 8'h01 || rst_code(c)) continue;
            sos = (c == 8'hDA);
            if (i >= n) break;
            h8 = bq[i++];
            exp_q.push_back({2'b00, h8});
            if (i >= n) break;
            l8 = bq[i++];
            exp_q.push_back({2'b00, l8});
            len = int'(h8) * 256 + int'(l8);
            if (len < 2) begin exp_err = 1; continue; end
            for (int k = 0; k < len - 2 && i < n; k++) exp_q.push_back({2'b00, bq[i++]});
            if (!sos) continue;
            while (i < n) begin
                b = bq[i++];
                if (b != 8'hFF) exp_q.push_back({2'b01, b});
                else begin
                    while (i < n && bq[i] == 8'hFF) i++;
                    if (i >= n) break;
                    c = bq[i++];
                    if (c == 8'h00) exp_q.push_back({2'b01, 8'hFF});
                    else if (rst_code(c)) exp_q.push_back({2'b10, c});
                    else begin code = int'(c); break; end
                end
            end
        end
        foreach (bad_at[k]) if (bad_at[k] <= eoi_idx) exp_err = 1;
    endtask

    function automatic string hexch(input int nb, input bit lower);
        logic [7:0] ch;
        ch = (nb < 10) ? 8'(48 + nb) : 8'((lower ? 87 : 55) + nb);
        return $sformatf("%c", ch);
    endfunction

    function automatic string gen_stream();
        logic [7:0] q[$];
        string      s;
        int         L, m;
        logic [7:0] b;
        q = '{8'hFF, 8'hD8};
        repeat ($urandom_range(2)) begin
            if ($urandom_range(3) == 0) q.push_back(8'hFF);
            q.push_back(8'hFF);
            if ($urandom_range(4) == 0) begin
                q.push_back($urandom_range(1) ? 8'h01 : 8'hD3);
            end else begin
                q.push_back(codes[$urandom_range(5)]);
                L = $urandom_range(2, 6);
                q.push_back(8'h00);
                q.push_back(8'(L));
                repeat (L - 2) q.push_back(8'($urandom_range(255)));
            end
        end
        L = $urandom_range(2, 5);
        q.push_back(8'hFF); q.push_back(8'hDA); q.push_back(8'h00); q.push_back(8'(L));
        repeat (L - 2) q.push_back(8'($urandom_range(255)));
        m = $urandom_range(4, 20);
        repeat (m) begin
            b = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom_range(255));
            q.push_back(b);
            if (b == 8'hFF) q.push_back(8'h00);
            if ($urandom_range(9) == 0) begin
                q.push_back(8'hFF);
                q.push_back(8'(8'hD0 + $urandom_range(7)));
            end
        end
        q.push_back(8'hFF); q.push_back(8'hD9); q.push_back(8'h12); q.push_back(8'h34);
        s = "";
        foreach (q[k]) begin
            s = {s, hexch(int'(q[k][7:4]), 1'($urandom_range(1)))};
            if ($urandom_range(50) == 0) s = {s, "G"};
            s = {s, hexch(int'(q[k][3:0]), 1'($urandom_range(1)))};
            case ($urandom_range(11))
                0: s = {s, "\n"};
                1: s = {s, " "};
                2: s = {s, "\r"};
                default: ;
            endcase
        end
        if ($urandom_range(1)) s = {s, "Zq"};
        return s;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char = 8'h00;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_stream(input string s, input int bp, input string name);
        logic [9:0] got_q[$];
        int k, cyc, budget, nexp;
        k = 0;
        cyc = 0;
        budget = s.len() * 20 + 200;
        apply_reset();
        model(s);
        while (k < s.len() && cyc < budget) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(99) >= bp);
            bus.in_valid = ($urandom_range(3) != 0);
            bus.in_char = s[k];
            #1;
            if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_marker, bus.out_scan, bus.out_data});
            if (bus.in_valid && bus.in_ready) k++;
            cyc++;
        end
        vectors++;
        if (k !== s.len()) begin
            miscompares++;
            $display("FAIL %s timeout: consumed %0d chars, required %0d", name, k, s.len());
        end
        repeat (4) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) got_q.push_back({bus.out_marker, bus.out_scan, bus.out_data});
        end
        nexp = exp_q.size();
        vectors++;
        if (got_q.size() !== nexp) begin
            miscompares++;
            $display("FAIL %s count: got %0d bytes, required %0d", name, got_q.size(), nexp);
        end
        for (int j = 0; j < nexp && j < got_q.size(); j++) begin
            vectors++;
            if (got_q[j] !== exp_q[j]) begin
                miscompares++;
                $display("FAIL %s byte[%0d]: got m/s/d=%b/%b/%h, required %b/%b/%h", name, j,
                         got_q[j][9], got_q[j][8], got_q[j][7:0], exp_q[j][9], exp_q[j][8], exp_q[j][7:0]);
            end
        end
        vectors++;
        if (bus.err !== exp_err) begin
            miscompares++;
            $display("FAIL %s err: got %b, required %b", name, bus.err, exp_err);
        end
        vectors++;
        if (bus.eoi_done !== exp_eoi) begin
            miscompares++;
            $display("FAIL %s eoi_done: got %b, required %b", name, bus.eoi_done, exp_eoi);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_data, bus.out_marker, bus.out_scan, bus.err, bus.eoi_done} !== 13'h0) begin
            miscompares++;
            $display("FAIL reset outputs: got v=%b d=%h m=%b s=%b e=%b eoi=%b, required all 0",
                     bus.out_valid, bus.out_data, bus.out_marker, bus.out_scan, bus.err, bus.eoi_done);
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset in_ready: got %b, required 1", bus.in_ready);
        end
    endtask

    task automatic feed_stalled(input string s);
        int k, cyc;
        k = 0;
        cyc = 0;
        while (k < s.len() && cyc < 50) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_char = s[k];
            bus.out_ready = 1'b0;
            #1;
            if (bus.in_ready) k++;
            cyc++;
        end
        vectors++;
        if (k !== s.len()) begin
            miscompares++;
            $display("FAIL stall feed timeout: consumed %0d, required %0d", k, s.len());
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        apply_reset();
        feed_stalled("FFD8");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char = "F";
        bus.out_ready = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency out_valid: got %b, required 1", bus.out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({bus.in_ready, bus.out_valid, bus.out_marker, bus.out_data} !== {3'b011, 8'hD8}) begin
                miscompares++;
                $display("FAIL stall cycle %0d: got rdy=%b v=%b m=%b d=%h, required 0/1/1/d8",
                         c, bus.in_ready, bus.out_valid, bus.out_marker, bus.out_data);
            end
            @(negedge clk);
            #1;
        end
        xfers = 0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        if (bus.out_valid && bus.out_ready) xfers++;
        @(negedge clk);
        #1;
        if (bus.out_valid) xfers++;
        vectors++;
        if (xfers !== 1) begin
            miscompares++;
            $display("FAIL release transfers: got %0d, required 1", xfers);
        end
        feed_stalled("FFD8");
        apply_reset();
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset pending output: got out_valid %b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_directed();
        run_stream("FFD8", 0, "soi");
        run_stream("FFDB0004AB\nCD12", 30, "dqt_then_junk");
        run_stream("FFDA00030112FF0034FFFFD0FFD9", 30, "scan_eoi");
        run_stream("FFDG8", 0, "bad_char_mid");
        run_stream("FFC00001FFD8", 20, "short_len");
        run_stream("F", 0, "half_nibble");
        run_stream("FD8", 0, "after_reset_phase");
        run_stream("FFE00002FFD8", 20, "len2_nonsos");
        run_stream("FFDA000255FF00", 20, "len2_sos");
        run_stream("FFE00003ABFFD8", 20, "len3");
        run_stream("FFC0FFFF0102030405060708090AFFD9", 20, "len_ffff");
        run_stream("FFD9FFD8GZ12", 10, "after_eoi");
        run_stream("FFFF00FFD8", 0, "mark_00");
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            run_stream(gen_stream(), int'($urandom_range(60)), $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_directed();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
